// File: rtl/pipe_pkg.sv
// Shared types for the decode/execute boundary: forwarding selects and the
// E-stage control bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam int         CTRL_AOPW = 5;
    localparam int         NUM_OPS   = 2;
    localparam logic [5:0] REG_ZERO  = 6'd0;

    typedef struct packed {
        logic                 regwrite;
        logic                 memread;
        logic                 memwrite;
        logic [CTRL_AOPW-1:0] aluop;
        logic [5:0]           rd;
    } ctrl_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// One decode-stage operand: picks register file, E result or M result.
module operand_fwd_mux
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] rf,
    input  logic [XLEN-1:0] ex,
    input  logic [XLEN-1:0] mem,
    output logic [XLEN-1:0] op
);

    always_comb begin
        op = rf;
        case (sel)
            FWD_EX:  op = ex;
            FWD_MEM: op = mem;
            default: op = rf;   // 2'b11 is illegal, falls back to the RF value
        endcase
    end

endmodule

// File: rtl/decode_exec_latch.sv
// D->E pipeline register with operand forwarding, load-use/flush bubbles,
// execute-busy hold and a saturating bubble counter.
module decode_exec_latch
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AOPW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            validD,
    input  logic [XLEN-1:0] pcD,
    input  logic [XLEN-1:0] immD,
    input  logic [AOPW-1:0] aluopD,
    input  logic [5:0]      rdD,
    input  logic            regwriteD,
    input  logic            memreadD,
    input  logic            memwriteD,
    input  logic [XLEN-1:0] rf0D,
    input  logic [XLEN-1:0] rf1D,
    input  logic [1:0]      forward0,
    input  logic [1:0]      forward1,
    input  logic            lwstall,
    input  logic [XLEN-1:0] resultE,
    input  logic [XLEN-1:0] resultM,
    input  logic            flushE,
    input  logic            holdE,
    output logic            validE,
    output logic [XLEN-1:0] pcE,
    output logic [XLEN-1:0] immE,
    output logic [AOPW-1:0] aluopE,
    output logic [5:0]      rdE,
    output logic            regwriteE,
    output logic            memreadE,
    output logic            memwriteE,
    output logic [XLEN-1:0] op0E,
    output logic [XLEN-1:0] op1E,
    output logic            stallD,
    output logic [CNTW-1:0] bubble_cnt
);

    if (AOPW != CTRL_AOPW) begin : g_bad_aopw
        $error("AOPW must match pipe_pkg::CTRL_AOPW");
    end

    logic [NUM_OPS-1:0][1:0]      fwd_sel;
    logic [NUM_OPS-1:0][XLEN-1:0] rf_d;
    logic [NUM_OPS-1:0][XLEN-1:0] op_d;

    assign fwd_sel = {forward1, forward0};
    assign rf_d    = {rf1D, rf0D};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        operand_fwd_mux #(.XLEN(XLEN)) u_mux (
            .sel (fwd_sel[i]),
            .rf  (rf_d[i]),
            .ex  (resultE),
            .mem (resultM),
            .op  (op_d[i])
        );
    end

    logic  ldst, bubble;
    ctrl_t ctrl_d, ctrlE;

    // A stall on an empty decode slot is meaningless, so it is masked here.
    assign ldst   = lwstall & validD;
    assign bubble = ~holdE & (flushE | ldst);
    assign stallD = rstn & (holdE | (ldst & ~flushE));

    always_comb begin
        ctrl_d          = '0;
        ctrl_d.regwrite = regwriteD & validD;
        ctrl_d.memread  = memreadD & validD;
        ctrl_d.memwrite = memwriteD & validD;
        ctrl_d.aluop    = aluopD;
        ctrl_d.rd       = rdD;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            validE     <= 1'b0;
            ctrlE      <= '0;
            pcE        <= '0;
            immE       <= '0;
            op0E       <= '0;
            op1E       <= '0;
            bubble_cnt <= '0;
        end else if (!holdE) begin
            if (bubble) begin
                // Data fields are left as-is; rd is zeroed so the hazard unit never matches it.
                validE         <= 1'b0;
                ctrlE.regwrite <= 1'b0;
                ctrlE.memread  <= 1'b0;
                ctrlE.memwrite <= 1'b0;
                ctrlE.rd       <= REG_ZERO;
                if (bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + CNTW'(1);
            end else begin
                validE <= validD;
                ctrlE  <= ctrl_d;
                pcE    <= pcD;
                immE   <= immD;
                op0E   <= op_d[0];
                op1E   <= op_d[1];
            end
        end
    end

    assign aluopE    = ctrlE.aluop;
    assign rdE       = ctrlE.rd;
    assign regwriteE = ctrlE.regwrite;
    assign memreadE  = ctrlE.memread;
    assign memwriteE = ctrlE.memwrite;

    a_fwd_legal: assert property (@(posedge clk) disable iff (!rstn)
        (forward0 != 2'b11) && (forward1 != 2'b11));

endmodule

// File: tb/tb_decode_exec_latch.sv
// Directed bench for decode_exec_latch; narrow counter so saturation is reachable.
module tb_decode_exec_latch;

    localparam int XLEN = 32;
    localparam int AOPW = 5;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            validD;
    logic [XLEN-1:0] pcD, immD, rf0D, rf1D, resultE, resultM;
    logic [AOPW-1:0] aluopD;
    logic [5:0]      rdD;
    logic            regwriteD, memreadD, memwriteD;
    logic [1:0]      forward0, forward1;
    logic            lwstall, flushE, holdE;
    logic            validE, regwriteE, memreadE, memwriteE, stallD;
    logic [XLEN-1:0] pcE, immE, op0E, op1E;
    logic [AOPW-1:0] aluopE;
    logic [5:0]      rdE;
    logic [CNTW-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    decode_exec_latch #(.XLEN(XLEN), .AOPW(AOPW), .CNTW(CNTW)) dut (
        .clk(clk), .rstn(rstn), .validD(validD), .pcD(pcD), .immD(immD),
        .aluopD(aluopD), .rdD(rdD), .regwriteD(regwriteD), .memreadD(memreadD),
        .memwriteD(memwriteD), .rf0D(rf0D), .rf1D(rf1D), .forward0(forward0),
        .forward1(forward1), .lwstall(lwstall), .resultE(resultE), .resultM(resultM),
        .flushE(flushE), .holdE(holdE), .validE(validE), .pcE(pcE), .immE(immE),
        .aluopE(aluopE), .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE),
        .memwriteE(memwriteE), .op0E(op0E), .op1E(op1E), .stallD(stallD),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        holdE = 1'b1;
        #2;
        checks++; if (validE !== 1'b0) begin errors++; $display("FAIL rst_validE got %0h exp 0", validE); end
        checks++; if (pcE !== '0 || immE !== '0 || op0E !== '0 || op1E !== '0) begin errors++; $display("FAIL rst_data got pc=%0h imm=%0h op0=%0h op1=%0h exp 0", pcE, immE, op0E, op1E); end
        checks++; if ({rdE, aluopE, regwriteE, memreadE, memwriteE} !== '0) begin errors++; $display("FAIL rst_ctrl got rd=%0h aluop=%0h exp 0", rdE, aluopE); end
        checks++; if (bubble_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bubble_cnt); end
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL rst_stallD got %0h exp 0", stallD); end
        tick();
        rstn  = 1'b1;
        holdE = 1'b0;
    endtask

    task automatic test_no_hazard();
        validD = 1'b1; pcD = 32'h100; immD = 32'h4; aluopD = 5'd3; rdD = 6'd5;
        regwriteD = 1'b1; memwriteD = 1'b1; rf0D = 32'h11; rf1D = 32'h22;
        forward0 = 2'b00; forward1 = 2'b00;
        #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL nohaz_stallD got %0h exp 0", stallD); end
        tick();
        checks++; if (op0E !== 32'h11) begin errors++; $display("FAIL nohaz_op0E got %0h exp 11", op0E); end
        checks++; if (op1E !== 32'h22) begin errors++; $display("FAIL nohaz_op1E got %0h exp 22", op1E); end
        checks++; if (validE !== 1'b1 || regwriteE !== 1'b1 || memwriteE !== 1'b1) begin errors++; $display("FAIL nohaz_ctrl got v=%0h rw=%0h mw=%0h exp 1 1 1", validE, regwriteE, memwriteE); end
        checks++; if (pcE !== 32'h100 || immE !== 32'h4 || aluopE !== 5'd3 || rdE !== 6'd5) begin errors++; $display("FAIL nohaz_fields got pc=%0h imm=%0h aluop=%0h rd=%0h exp 100 4 3 5", pcE, immE, aluopE, rdE); end
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL nohaz_stallD2 got %0h exp 0", stallD); end
        memwriteD = 1'b0;
    endtask

    task automatic test_forward();
        forward1 = 2'b01; resultE = 32'hAA;
        tick();
        checks++; if (op1E !== 32'hAA) begin errors++; $display("FAIL fwd_ex_op1E got %0h exp aa", op1E); end
        checks++; if (op0E !== 32'h11) begin errors++; $display("FAIL fwd_ex_op0E got %0h exp 11", op0E); end
        forward1 = 2'b10; forward0 = 2'b10; resultM = 32'hBB;
        tick();
        checks++; if (op1E !== 32'hBB) begin errors++; $display("FAIL fwd_mem_op1E got %0h exp bb", op1E); end
        checks++; if (op0E !== 32'hBB) begin errors++; $display("FAIL fwd_mem_op0E got %0h exp bb", op0E); end
        forward0 = 2'b00; forward1 = 2'b00;
    endtask

    task automatic test_load_use();
        pcD = 32'h104; rdD = 6'd6; memreadD = 1'b1; lwstall = 1'b1;
        #1;
        checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL lu_stallD got %0h exp 1", stallD); end
        tick();
        checks++; if (validE !== 1'b0 || regwriteE !== 1'b0 || memreadE !== 1'b0) begin errors++; $display("FAIL lu_bubble_ctrl got v=%0h rw=%0h mr=%0h exp 0", validE, regwriteE, memreadE); end
        checks++; if (rdE !== 6'd0) begin errors++; $display("FAIL lu_rdE got %0h exp 0", rdE); end
        checks++; if (bubble_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", bubble_cnt); end
        checks++; if (pcE !== 32'h100) begin errors++; $display("FAIL lu_pc_held got %0h exp 100", pcE); end
        lwstall = 1'b0;
        #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL lu_stallD_clear got %0h exp 0", stallD); end
        tick();
        checks++; if (validE !== 1'b1 || pcE !== 32'h104 || rdE !== 6'd6 || memreadE !== 1'b1) begin errors++; $display("FAIL lu_reload got v=%0h pc=%0h rd=%0h mr=%0h exp 1 104 6 1", validE, pcE, rdE, memreadE); end
        memreadD = 1'b0;
    endtask

    task automatic test_back_to_back();
        lwstall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL b2b_stallD[%0d] got %0h exp 1", i, stallD); end
            tick();
            checks++; if (validE !== 1'b0 || rdE !== 6'd0) begin errors++; $display("FAIL b2b_bubble[%0d] got v=%0h rd=%0h exp 0 0", i, validE, rdE); end
        end
        checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL b2b_cnt got %0d exp 3", bubble_cnt); end
        lwstall = 1'b0;
    endtask

    task automatic test_lwstall_invalid();
        validD = 1'b0; lwstall = 1'b1; rdD = 6'd7; regwriteD = 1'b1;
        #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL lwinv_stallD got %0h exp 0", stallD); end
        tick();
        checks++; if (validE !== 1'b0 || regwriteE !== 1'b0 || rdE !== 6'd7) begin errors++; $display("FAIL lwinv_load got v=%0h rw=%0h rd=%0h exp 0 0 7", validE, regwriteE, rdE); end
        checks++; if (bubble_cnt !== 4'd3) begin errors++; $display("FAIL lwinv_cnt got %0d exp 3", bubble_cnt); end
        lwstall = 1'b0; validD = 1'b1;
    endtask

    task automatic test_flush_lw();
        pcD = 32'h108; rdD = 6'd8; memwriteD = 1'b1;
        tick();
        checks++; if (validE !== 1'b1 || rdE !== 6'd8 || memwriteE !== 1'b1) begin errors++; $display("FAIL fl_preload got v=%0h rd=%0h mw=%0h exp 1 8 1", validE, rdE, memwriteE); end
        flushE = 1'b1; lwstall = 1'b1;
        #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL fl_stallD got %0h exp 0", stallD); end
        tick();
        checks++; if (validE !== 1'b0 || rdE !== 6'd0 || memwriteE !== 1'b0 || regwriteE !== 1'b0) begin errors++; $display("FAIL fl_bubble got v=%0h rd=%0h mw=%0h rw=%0h exp 0", validE, rdE, memwriteE, regwriteE); end
        checks++; if (bubble_cnt !== 4'd4) begin errors++; $display("FAIL fl_cnt got %0d exp 4", bubble_cnt); end
        flushE = 1'b0; lwstall = 1'b0; memwriteD = 1'b0;
    endtask

    task automatic test_hold();
        pcD = 32'h200; rdD = 6'd9; rf0D = 32'h33;
        tick();
        holdE = 1'b1; flushE = 1'b1; pcD = 32'h300; rdD = 6'd10; rf0D = 32'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stallD !== 1'b1) begin errors++; $display("FAIL hold_stallD[%0d] got %0h exp 1", i, stallD); end
            tick();
            checks++; if (validE !== 1'b1 || pcE !== 32'h200 || rdE !== 6'd9 || op0E !== 32'h33) begin errors++; $display("FAIL hold_keep[%0d] got v=%0h pc=%0h rd=%0h op0=%0h exp 1 200 9 33", i, validE, pcE, rdE, op0E); end
            checks++; if (bubble_cnt !== 4'd4) begin errors++; $display("FAIL hold_cnt[%0d] got %0d exp 4", i, bubble_cnt); end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (validE !== 1'b0 || pcE !== '0 || op0E !== '0 || rdE !== '0 || regwriteE !== 1'b0) begin errors++; $display("FAIL arst_out got v=%0h pc=%0h op0=%0h rd=%0h rw=%0h exp 0", validE, pcE, op0E, rdE, regwriteE); end
        checks++; if (bubble_cnt !== '0 || stallD !== 1'b0) begin errors++; $display("FAIL arst_cnt_stall got cnt=%0d stall=%0h exp 0 0", bubble_cnt, stallD); end
        #1;
        rstn = 1'b1; holdE = 1'b0; flushE = 1'b0;
        tick();
        checks++; if (validE !== 1'b1 || pcE !== 32'h300 || rdE !== 6'd10 || op0E !== 32'h44) begin errors++; $display("FAIL arst_first got v=%0h pc=%0h rd=%0h op0=%0h exp 1 300 a 44", validE, pcE, rdE, op0E); end
    endtask

    task automatic test_saturation();
        flushE = 1'b1;
        #1;
        checks++; if (stallD !== 1'b0) begin errors++; $display("FAIL sat_stallD got %0h exp 0", stallD); end
        repeat (15) tick();
        checks++; if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_full got %0d exp 15", bubble_cnt); end
        tick();
        checks++; if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d exp 15", bubble_cnt); end
        flushE = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; validD = 1'b0; pcD = '0; immD = '0; aluopD = '0; rdD = '0;
        regwriteD = 1'b0; memreadD = 1'b0; memwriteD = 1'b0; rf0D = '0; rf1D = '0;
        forward0 = 2'b00; forward1 = 2'b00; lwstall = 1'b0; resultE = '0; resultM = '0;
        flushE = 1'b0; holdE = 1'b0;
        test_reset();
        test_no_hazard();
        test_forward();
        test_load_use();
        test_back_to_back();
        test_lwstall_invalid();
        test_flush_lw();
        test_hold();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_exec_latch.md
# decode_exec_latch

Decode-to-execute boundary of the 1st core pipeline. The block sits directly downstream of the hazard unit and consumes its `forward0`/`forward1`/`lwstall` outputs. It selects forwarded decode-stage operands, inserts bubbles on load-use stalls and flushes, and holds on execute-busy. It registers everything into the E stage, and its `rdE`/`regwriteE`/`memreadE` outputs feed back into the hazard unit.

## Interface
- `XLEN`, 32, operand/PC/immediate width
- `AOPW`, 5, ALU opcode width
- `CNTW`, 32, bubble counter width

Ports:
- `clk`  in  1  core clock; all state on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `validD`  in  1  decode slot holds a real instruction
- `pcD`  in  XLEN  decode PC
- `immD`  in  XLEN  decoded immediate
- `aluopD`  in  AOPW  ALU opcode
- `rdD`  in  6  destination register
- `regwriteD` / `memreadD` / `memwriteD`  in  1 each  decoded controls
- `rf0D` / `rf1D`  in  XLEN each  register-file read data
- `forward0` / `forward1`  in  2 each  hazard-unit operand selects
- `lwstall`  in  1  hazard-unit load-use stall
- `resultE`  in  XLEN  E-stage result, combinational this cycle
- `resultM`  in  XLEN  M-stage result
- `flushE`  in  1  redirect; kill the instruction entering E
- `holdE`  in  1  E stage busy (multi-cycle unit)
- `validE`, `pcE`, `immE`, `aluopE`, `rdE`, `regwriteE`, `memreadE`, `memwriteE`  out  matching widths  E-stage register contents
- `op0E` / `op1E`  out  XLEN each  forwarded operands
- `stallD`  out  1  freeze fetch/decode registers this cycle
- `bubble_cnt`  out  CNTW  count of bubbles inserted since reset

## Operation
- Operand select for each of the two operands:
  - 2'b00 selects `rfND`.
  - 2'b01 selects `resultE`.
  - 2'b10 selects `resultM`.
  - 2'b11 is illegal; it selects `rfND` and fires an assertion.
- Effective stall: `ldst = lwstall & validD`.
- Per-cycle E-register action, highest priority first:
  1. `holdE=1`: HOLD. All E registers keep their value, including `op0E`/`op1E`.
  2. `flushE=1`: BUBBLE.
  3. `ldst=1`: BUBBLE.
  4. Otherwise: LOAD. All fields take the D inputs and the selected operands.
- BUBBLE behaviour:
  - `validE`, `regwriteE`, `memreadE` and `memwriteE` go to 0.
  - `rdE` goes to 0, so a stale `rdE` can never match in the hazard unit.
  - Data fields (`pcE`, `immE`, `aluopE`, `op0E`, `op1E`) are don't-care; they are held.
- `stallD` is combinational: `holdE | (ldst & ~flushE)`. A flush overrides a load-use stall, because the younger decode instruction is being discarded upstream anyway.
- `bubble_cnt` increments by 1 on every BUBBLE cycle caused by `ldst` or `flushE` while `holdE=0`. It saturates at all-ones and does not wrap.
- Hold or flush with `validD=0` behaves as specified above. `lwstall` with `validD=0` is ignored (LOAD of an invalid slot with `validE=0`).
- On LOAD, `validE` takes `validD`; control bits are ANDed with `validD`.

## Timing
- One-cycle latency: D inputs in cycle n appear on the E outputs after edge n+1.
- `stallD`, together with the operand select and mux path, is combinational within the cycle.
- Reset: while `rstn=0`, all outputs are 0 asynchronously, including `bubble_cnt`. `stallD` = 0 during reset because `holdE` is ignored.
- Reset deasserting mid-stall: the first post-reset cycle evaluates normally from the current inputs.
- Back-to-back load-use stalls insert one bubble per cycle. The hazard unit drops `lwstall` once the load has moved to M, so a single-cycle stall is expected.
- `holdE` asserted for k cycles keeps the E outputs stable for exactly k edges; `stallD`=1 throughout.

## Structure
- Package `pipe_pkg` holds:
  - `fwd_sel_e` enum: `FWD_RF`=2'b00, `FWD_EX`=2'b01, `FWD_MEM`=2'b10.
  - Packed struct `ctrl_t` {`regwrite`, `memread`, `memwrite`, `aluop`, `rd`}.
  - `REG_ZERO`=6'd0.
- Sub-module `operand_fwd_mux`, instantiated twice, one per operand.
- E-stage state: one `ctrl_t` register plus data registers and `validE`.

## Test plan
- No hazards: `forward0`=00, `rf0D`=0x11, `validD`=1 → after one edge `op0E`=0x11, `validE`=1, `stallD`=0 throughout.
- Forward select: `forward1`=01 with `resultE`=0xAA, then `forward1`=10 with `resultM`=0xBB → `op1E`=0xAA, then 0xBB on successive edges.
- Load-use: `lwstall`=1 and `validD`=1 for one cycle → `stallD`=1; next edge gives `validE`=0, `regwriteE`=0, `rdE`=0; `bubble_cnt` 0→1.
- Flush plus `lwstall` in the same cycle → bubble, `stallD`=0, `bubble_cnt` +1 once only.
- `holdE` for 3 cycles alongside `flushE`=1 → E outputs unchanged for 3 edges, `stallD`=1, `bubble_cnt` unchanged.
- Assert `rstn`=0 asynchronously mid-hold with `validE`=1 → all outputs 0 immediately, before the next clock edge; `bubble_cnt` reaches all-ones, then one more bubble → stays all-ones.
